// File: rtl/color_pattern_check.sv
// Read-back checker for the colour-bar test frame held in frame SRAM.
// It sweeps the frame one read per clock and compares each returned word
// against the bar colour expected at that pixel position.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   enable                level start, sampled while idle
//   starting_address      frame base address, latched at start
//   data_read             SRAM read data, valid READ_LATENCY clocks after addr
//   addr, wren            SRAM address (registered), write enable (always 0)
//   done, pass            check complete, zero-mismatch flag (valid with done)
//   error_count           saturating mismatch count
//   first_error_addr/data address and data of the first mismatch
module color_pattern_check #(
  parameter int unsigned IMG_WIDTH    = 32,
  parameter int unsigned IMG_HEIGHT   = 32,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [17:0] starting_address,
  input  logic [31:0] data_read,
  output logic [17:0] addr,
  output logic        wren,
  output logic        done,
  output logic        pass,
  output logic [10:0] error_count,
  output logic [17:0] first_error_addr,
  output logic [31:0] first_error_data
);

  localparam int unsigned AW       = 18;
  localparam int unsigned DW       = 32;
  localparam int unsigned CW       = 11;
  localparam int unsigned HW       = $clog2(IMG_WIDTH);
  localparam int unsigned VW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned BH       = IMG_HEIGHT / 2;
  localparam int unsigned MH       = IMG_HEIGHT / 4;
  localparam int unsigned SUB_LSB  = HW - 5;
  // Issue stage (aligned with addr) followed by READ_LATENCY delay stages.
  localparam int unsigned PIPE     = READ_LATENCY + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  state_e          state_q;
  logic [AW-1:0]   base_q;
  logic [HW-1:0]   h_q;
  logic [VW-1:0]   v_q;
  logic [2:0]      drain_q;
  logic [AW-1:0]   addr_q;
  logic            done_q;
  logic            pass_q;
  logic [CW-1:0]   err_q;
  logic [CW-1:0]   err_d;
  logic            seen_q;
  logic [AW-1:0]   fea_q;
  logic [DW-1:0]   fed_q;
  logic [PIPE-1:0] vld_q;
  logic [DW-1:0]   exp_q [PIPE];
  logic [AW-1:0]   pa_q  [PIPE];

  logic [AW-1:0]   pix_addr_d;
  logic [DW-1:0]   exp_d;
  logic            push_c;
  logic            mismatch_c;
  logic            last_pix_c;

  // Expected 24-bit colour for pixel (h, v); bar index is the top 3 bits of h.
  function automatic logic [23:0] bar_colour(input logic [HW-1:0] h, input logic [VW-1:0] v);
    logic [2:0]  bar;
    logic [1:0]  sub;
    logic [23:0] c;
    bar = h[HW-1 -: 3];
    sub = h[SUB_LSB +: 2];
    c   = 24'h000000;
    if (32'(v) < BH) begin
      case (bar)
        3'd0: c = 24'hc0c0c0;
        3'd1: c = 24'hc0c000;
        3'd2: c = 24'h00c0c0;
        3'd3: c = 24'h00c000;
        3'd4: c = 24'hc000c0;
        3'd5: c = 24'hc00000;
        3'd6: c = 24'h0000c0;
        default: c = 24'hffffff;
      endcase
    end else if (32'(v) < BH + MH) begin
      case (bar)
        3'd0: c = 24'h0000c0;
        3'd2: c = 24'hc000c0;
        3'd4: c = 24'h00c0c0;
        3'd6: c = 24'hc0c0c0;
        default: c = 24'h131313;
      endcase
    end else begin
      case (bar)
        3'd0: c = 24'h00214c;
        3'd1: c = 24'hffffff;
        3'd2: c = 24'h32006a;
        3'd3: c = 24'h131313;
        // Bar 4 is split into quarter-bar segments (MW wide each).
        3'd4: begin
          case (sub)
            2'd1:    c = 24'h131313;
            2'd2:    c = 24'h1d1d1d;
            default: c = 24'h090909;
          endcase
        end
        3'd6: c = 24'hc0c0c0;
        default: c = 24'h131313;
      endcase
    end
    return c;
  endfunction

  // Pixel address: base + 1 + v*W + h; W is a power of two so v*W+h is {v,h}.
  always_comb begin
    pix_addr_d = base_q + AW'(1) + AW'({v_q, h_q});
    exp_d      = {8'h00, bar_colour(h_q, v_q)};
    push_c     = (state_q == S_READ);
    last_pix_c = (h_q == HW'(IMG_WIDTH - 1)) && (v_q == VW'(IMG_HEIGHT - 1));
  end

  // Compare the entry leaving the pipeline against the returned word.
  always_comb begin
    mismatch_c = vld_q[PIPE-1] && (data_read != exp_q[PIPE-1]);
    err_d      = err_q;
    if (mismatch_c && (err_q != CNT_MAX)) begin
      err_d = err_q + CW'(1);
    end
  end

  // Sweep FSM, expected-value pipeline and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      h_q     <= '0;
      v_q     <= '0;
      drain_q <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      seen_q  <= 1'b0;
      fea_q   <= '0;
      fed_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < int'(PIPE); i++) begin
        exp_q[i] <= '0;
        pa_q[i]  <= '0;
      end
    end else begin
      vld_q    <= {vld_q[PIPE-2:0], push_c};
      exp_q[0] <= exp_d;
      pa_q[0]  <= pix_addr_d;
      for (int i = 1; i < int'(PIPE); i++) begin
        exp_q[i] <= exp_q[i-1];
        pa_q[i]  <= pa_q[i-1];
      end

      if (mismatch_c) begin
        err_q <= err_d;
        if (!seen_q) begin
          seen_q <= 1'b1;
          fea_q  <= pa_q[PIPE-1];
          fed_q  <= data_read;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (enable) begin
            base_q  <= starting_address;
            err_q   <= '0;
            seen_q  <= 1'b0;
            fea_q   <= '0;
            fed_q   <= '0;
            pass_q  <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            state_q <= S_READ;
          end
        end
        S_READ: begin
          addr_q <= pix_addr_d;
          h_q    <= h_q + HW'(1);
          if (h_q == HW'(IMG_WIDTH - 1)) begin
            v_q <= v_q + VW'(1);
          end
          if (last_pix_c) begin
            drain_q <= '0;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Last entry is compared on the same edge that enters DONE.
          if (drain_q == 3'(READ_LATENCY)) begin
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= S_DONE;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        S_DONE: begin
          if (!enable) begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign addr             = addr_q;
  assign wren             = 1'b0;
  assign done             = done_q;
  assign pass             = pass_q;
  assign error_count      = err_q;
  assign first_error_addr = fea_q;
  assign first_error_data = fed_q;

endmodule
